// File: rtl/fft_out_reorder.sv
// Ping-pong collector: captures a bit-reversed 16-word FFT frame in one edge and streams it out in natural bin order.
// Latency: bin 0 presented the cycle after capture; then one beat per cycle while out_ready is high.
// Backpressure: out_ready low holds the current beat; in_ready drops only when both banks hold undrained frames.
module fft_out_reorder #(
    parameter int DW   = 32,
    parameter int IDXW = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [(2**IDXW)*DW-1:0]  in_vec,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DW-1:0]            out_data,
    output logic [DW/2-1:0]          out_real,
    output logic [DW/2-1:0]          out_imag,
    output logic [IDXW-1:0]          out_index,
    output logic                     out_last,
    output logic                     err_drop
);

    localparam int NW = 2**IDXW;

    typedef logic [NW-1:0][DW-1:0] frame_t;

    frame_t          bank [2];
    logic [1:0]      full;
    logic [1:0]      full_nxt;
    logic            wr_bank;
    logic            rd_bank;
    logic [IDXW-1:0] rd_cnt;
    logic [IDXW-1:0] rd_addr;
    frame_t          rd_frame;
    logic            capture;
    logic            beat;
    logic            beat_final;

    function automatic logic [IDXW-1:0] bitrev(input logic [IDXW-1:0] v);
        logic [IDXW-1:0] r;
        r = '0;
        for (int i = 0; i < IDXW; i++) begin
            r[i] = v[IDXW-1-i];
        end
        return r;
    endfunction

    assign in_ready   = !full[wr_bank];
    assign capture    = in_valid && in_ready;
    assign out_valid  = full[rd_bank];
    assign beat       = out_valid && out_ready;
    assign beat_final = beat && (rd_cnt == {IDXW{1'b1}});

    // Butterfly port k carries bin bitrev(k), so natural bin n lives at port bitrev(n).
    assign rd_addr   = bitrev(rd_cnt);
    assign rd_frame  = bank[rd_bank];
    assign out_data  = out_valid ? rd_frame[rd_addr] : '0;
    assign out_real  = out_data[DW-1:DW/2];
    assign out_imag  = out_data[DW/2-1:0];
    assign out_index = rd_cnt;
    assign out_last  = out_valid && (rd_cnt == {IDXW{1'b1}});

    // Capture and final beat always hit different banks, so both updates compose.
    always_comb begin
        full_nxt = full;
        if (beat_final) begin
            full_nxt[rd_bank] = 1'b0;
        end
        if (capture) begin
            full_nxt[wr_bank] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full     <= '0;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            rd_cnt   <= '0;
            err_drop <= 1'b0;
        end else begin
            full <= full_nxt;
            if (capture) begin
                wr_bank <= ~wr_bank;
            end
            if (in_valid && !in_ready) begin
                err_drop <= 1'b1;
            end
            if (beat) begin
                rd_cnt <= rd_cnt + IDXW'(1);
            end
            if (beat_final) begin
                rd_bank <= ~rd_bank;
            end
        end
    end

    // Frame storage carries no reset; validity is tracked solely by the full flags.
    always_ff @(posedge clk) begin
        if (capture) begin
            bank[wr_bank] <= in_vec;
        end
    end

endmodule
